// File: rtl/fft_istream_frontend.sv
// fft_istream_frontend: captures NUM_CH complex streams into even/odd half-banks in bit-reversed order and sequences frames to the FFT core
// Ports: clk/rst (sync, active-low); cfg_log2len, autorun, run, fin control the frame flow;
//   sact_istream/s_ready and sdw_istream_* carry input samples; wact_even/wact_odd/wa/wdw write the half-banks;
//   fft_start/fft_done handshake with the core; cur_log2len, max_bw, frame_bw, status, done, frame_cnt, drop_cnt report state.
module fft_istream_frontend #(
  parameter int MAX_FFT_LENGTH = 1024,
  parameter int FFT_DW = 16,
  parameter int NUM_CH = 2,
  localparam int MAX_N = $clog2(MAX_FFT_LENGTH),
  localparam int LENW = $clog2(MAX_N + 1),
  localparam int FFT_BFPDW = $clog2(FFT_DW) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LENW-1:0]               cfg_log2len,
  input  logic                          autorun,
  input  logic                          run,
  input  logic                          fin,
  input  logic                          sact_istream,
  output logic                          s_ready,
  input  logic [NUM_CH*FFT_DW-1:0]      sdw_istream_real,
  input  logic [NUM_CH*FFT_DW-1:0]      sdw_istream_imag,
  output logic                          wact_even,
  output logic                          wact_odd,
  output logic [MAX_N-2:0]              wa,
  output logic [NUM_CH*2*FFT_DW-1:0]    wdw,
  output logic                          fft_start,
  input  logic                          fft_done,
  output logic [LENW-1:0]               cur_log2len,
  output logic [NUM_CH*FFT_BFPDW-1:0]   max_bw,
  output logic [FFT_BFPDW-1:0]          frame_bw,
  output logic [2:0]                    status,
  output logic                          done,
  output logic [15:0]                   frame_cnt,
  output logic [7:0]                    drop_cnt
);
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INPUT_STREAM = 3'd1,
    ST_FULL_BUFFER = 3'd2,
    ST_RUN_FFT = 3'd3,
    ST_DONE = 3'd4
  } state_e;
  state_e state_q;
  logic [MAX_N-1:0] k_q, rev, r, last_k;
  logic [LENW-1:0] cur_log2len_q, sh, len_clamp;
  logic [NUM_CH*FFT_BFPDW-1:0] max_bw_q, max_bw_d;
  logic [FFT_BFPDW-1:0] sbw [NUM_CH];
  logic [15:0] frame_cnt_q;
  logic [7:0] drop_cnt_q;
  logic fft_start_q, accept, last, enter;
  // Smallest two's-complement width: fold negatives onto their one's complement, then find the top set bit.
  function automatic logic [FFT_BFPDW-1:0] bw_of(input logic [FFT_DW-1:0] x);
    logic [FFT_DW-1:0] y;
    y = x[FFT_DW-1] ? ~x : x;
    bw_of = FFT_BFPDW'(1);
    for (int i = 0; i < FFT_DW; i++) if (y[i]) bw_of = FFT_BFPDW'(i + 2);
  endfunction
  assign s_ready = state_q == ST_INPUT_STREAM;
  assign accept = sact_istream && s_ready;
  assign sh = LENW'(MAX_N) - cur_log2len_q;
  // Reversing all MAX_N bits then shifting down by the unused span gives the L-bit reversal.
  assign rev = {<<{k_q}};
  assign r = rev >> sh;
  assign last_k = {MAX_N{1'b1}} >> sh;
  assign last = k_q == last_k;
  assign wact_even = accept && !r[0];
  assign wact_odd = accept && r[0];
  assign wa = r[MAX_N-1:1];
  assign enter = state_q == ST_IDLE || (state_q == ST_DONE && fin);
  assign len_clamp = cfg_log2len < LENW'(2) ? LENW'(2) : cfg_log2len > LENW'(MAX_N) ? LENW'(MAX_N) : cfg_log2len;
  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic [FFT_BFPDW-1:0] br, bi;
    assign br = bw_of(sdw_istream_real[c*FFT_DW +: FFT_DW]);
    assign bi = bw_of(sdw_istream_imag[c*FFT_DW +: FFT_DW]);
    assign sbw[c] = br > bi ? br : bi;
    assign wdw[c*2*FFT_DW +: 2*FFT_DW] = {sdw_istream_imag[c*FFT_DW +: FFT_DW], sdw_istream_real[c*FFT_DW +: FFT_DW]};
  end
  always_comb begin
    max_bw_d = max_bw_q;
    for (int i = 0; i < NUM_CH; i++)
      max_bw_d[i*FFT_BFPDW +: FFT_BFPDW] = (accept && sbw[i] > max_bw_q[i*FFT_BFPDW +: FFT_BFPDW]) ? sbw[i] : max_bw_q[i*FFT_BFPDW +: FFT_BFPDW];
  end
  always_comb begin
    frame_bw = '0;
    for (int i = 0; i < NUM_CH; i++)
      frame_bw = max_bw_q[i*FFT_BFPDW +: FFT_BFPDW] > frame_bw ? max_bw_q[i*FFT_BFPDW +: FFT_BFPDW] : frame_bw;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q <= '0;
      cur_log2len_q <= LENW'(MAX_N);
      max_bw_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q <= '0;
      fft_start_q <= 1'b0;
    end else begin
      fft_start_q <= 1'b0;
      max_bw_q <= max_bw_d;
      if (sact_istream && !s_ready && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      case (state_q)
        ST_IDLE: state_q <= ST_INPUT_STREAM;
        ST_INPUT_STREAM:
          if (accept && last) begin
            state_q <= autorun ? ST_RUN_FFT : ST_FULL_BUFFER;
            fft_start_q <= autorun;
          end else if (accept) k_q <= k_q + MAX_N'(1);
        ST_FULL_BUFFER:
          if (run) begin
            state_q <= ST_RUN_FFT;
            fft_start_q <= 1'b1;
          end
        ST_RUN_FFT:
          if (fft_done) begin
            state_q <= ST_DONE;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        ST_DONE: if (fin) state_q <= ST_INPUT_STREAM;
        default: state_q <= ST_IDLE;
      endcase
      if (enter) begin
        k_q <= '0;
        max_bw_q <= '0;
        cur_log2len_q <= len_clamp;
      end
    end
  end
  assign fft_start = fft_start_q;
  assign cur_log2len = cur_log2len_q;
  assign max_bw = max_bw_q;
  assign status = state_q;
  assign done = state_q == ST_DONE;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_fft_istream_frontend.sv
// tb_fft_istream_frontend: directed table-driven bench for fft_istream_frontend
module tb_fft_istream_frontend;
  logic clk = 0, rst = 0, autorun = 0, run = 0, fin = 0, sact_istream = 0, fft_done = 0;
  logic [3:0] cfg_log2len = 4'd3;
  logic [31:0] sdw_istream_real = '0, sdw_istream_imag = '0;
  logic s_ready, wact_even, wact_odd, fft_start, done;
  logic [8:0] wa;
  logic [63:0] wdw;
  logic [3:0] cur_log2len;
  logic [9:0] max_bw;
  logic [4:0] frame_bw;
  logic [2:0] status;
  logic [15:0] frame_cnt;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] re0, im0, re1;
    logic we, wo;
    logic [8:0] wa;
  } vec_t;
  vec_t tbl [12];
  fft_istream_frontend dut (
    .clk(clk), .rst(rst), .cfg_log2len(cfg_log2len), .autorun(autorun), .run(run), .fin(fin),
    .sact_istream(sact_istream), .s_ready(s_ready), .sdw_istream_real(sdw_istream_real),
    .sdw_istream_imag(sdw_istream_imag), .wact_even(wact_even), .wact_odd(wact_odd), .wa(wa),
    .wdw(wdw), .fft_start(fft_start), .fft_done(fft_done), .cur_log2len(cur_log2len),
    .max_bw(max_bw), .frame_bw(frame_bw), .status(status), .done(done), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sact_istream = 1;
      sdw_istream_real = {tbl[i].re1, tbl[i].re0};
      sdw_istream_imag = {16'h0, tbl[i].im0};
      #1;
      chk($sformatf("we[%0d]", i), wact_even, tbl[i].we);
      chk($sformatf("wo[%0d]", i), wact_odd, tbl[i].wo);
      chk($sformatf("wa[%0d]", i), wa, tbl[i].wa);
      chk($sformatf("wdw[%0d]", i), wdw, {16'h0, tbl[i].re1, tbl[i].im0, tbl[i].re0});
      chk($sformatf("s_ready[%0d]", i), s_ready, 1'b1);
      tick();
    end
    sact_istream = 0;
  endtask
  initial begin
    logic strobe_seen;
    tbl[0] = '{16'd0, 16'd1, 16'd0, 1, 0, 9'd0};
    tbl[1] = '{16'd1, 16'd1, 16'd0, 1, 0, 9'd2};
    tbl[2] = '{16'd2, 16'd1, 16'd0, 1, 0, 9'd1};
    tbl[3] = '{16'd3, 16'd1, 16'd0, 1, 0, 9'd3};
    tbl[4] = '{16'd4, 16'd1, 16'd0, 0, 1, 9'd0};
    tbl[5] = '{16'd5, 16'd1, 16'd0, 0, 1, 9'd2};
    tbl[6] = '{16'd6, 16'd1, 16'd0, 0, 1, 9'd1};
    tbl[7] = '{16'd7, 16'd1, 16'd0, 0, 1, 9'd3};
    tbl[8] = '{16'd3, 16'd1, 16'd0, 1, 0, 9'd0};
    tbl[9] = '{16'hFFFC, 16'd1, 16'h8000, 1, 0, 9'd1};
    tbl[10] = '{16'd0, 16'd1, 16'd0, 0, 1, 9'd0};
    tbl[11] = '{16'd0, 16'd1, 16'd0, 0, 1, 9'd1};
    tick();
    tick();
    chk("rst status", status, 3'd0);
    chk("rst cur_log2len", cur_log2len, 4'd10);
    chk("rst max_bw", max_bw, 10'd0);
    chk("rst frame_cnt", frame_cnt, 16'd0);
    chk("rst drop_cnt", drop_cnt, 8'd0);
    chk("rst s_ready", s_ready, 1'b0);
    chk("rst fft_start", fft_start, 1'b0);
    rst = 1;
    autorun = 1;
    cfg_log2len = 4'd3;
    tick();
    chk("f1 status", status, 3'd1);
    chk("f1 cur_log2len", cur_log2len, 4'd3);
    apply(0, 7);
    chk("f1 autorun status", status, 3'd3);
    chk("f1 fft_start", fft_start, 1'b1);
    chk("f1 max_bw", max_bw, {5'd1, 5'd4});
    chk("f1 frame_bw", frame_bw, 5'd4);
    tick();
    chk("f1 fft_start once", fft_start, 1'b0);
    chk("f1 still run", status, 3'd3);
    fft_done = 1;
    tick();
    fft_done = 0;
    chk("f1 done status", status, 3'd4);
    chk("f1 done", done, 1'b1);
    chk("f1 frame_cnt", frame_cnt, 16'd1);
    autorun = 0;
    cfg_log2len = 4'd1;
    fin = 1;
    tick();
    fin = 0;
    chk("f2 status", status, 3'd1);
    chk("f2 clamp low", cur_log2len, 4'd2);
    chk("f2 max_bw clear", max_bw, 10'd0);
    run = 1;
    tick();
    run = 0;
    chk("f2 run ignored", status, 3'd1);
    cfg_log2len = 4'd15;
    apply(8, 11);
    chk("f2 full status", status, 3'd2);
    chk("f2 no start", fft_start, 1'b0);
    chk("f2 cur held", cur_log2len, 4'd2);
    chk("f2 max_bw", max_bw, {5'd16, 5'd3});
    chk("f2 frame_bw", frame_bw, 5'd16);
    fft_done = 1;
    fin = 1;
    tick();
    fft_done = 0;
    fin = 0;
    chk("f2 done/fin ignored", status, 3'd2);
    run = 1;
    tick();
    run = 0;
    chk("f2 run status", status, 3'd3);
    chk("f2 fft_start", fft_start, 1'b1);
    tick();
    chk("f2 fft_start once", fft_start, 1'b0);
    fft_done = 1;
    tick();
    fft_done = 0;
    chk("f2 frame_cnt", frame_cnt, 16'd2);
    chk("f2 max_bw held", max_bw, {5'd16, 5'd3});
    strobe_seen = 0;
    sact_istream = 1;
    for (int i = 0; i < 300; i++) begin
      if (wact_even || wact_odd) strobe_seen = 1;
      tick();
    end
    sact_istream = 0;
    chk("drop no strobe", strobe_seen, 1'b0);
    chk("drop sat", drop_cnt, 8'd255);
    fin = 1;
    tick();
    fin = 0;
    chk("f3 clamp high", cur_log2len, 4'd10);
    chk("f3 max_bw clear", max_bw, 10'd0);
    for (int i = 0; i < 5; i++) begin
      sact_istream = 1;
      sdw_istream_real = {16'd0, 16'(100 + i)};
      sdw_istream_imag = '0;
      tick();
    end
    rst = 0;
    tick();
    sact_istream = 0;
    chk("mid rst status", status, 3'd0);
    chk("mid rst max_bw", max_bw, 10'd0);
    chk("mid rst frame_cnt", frame_cnt, 16'd0);
    chk("mid rst drop_cnt", drop_cnt, 8'd0);
    chk("mid rst fft_start", fft_start, 1'b0);
    chk("mid rst s_ready", s_ready, 1'b0);
    rst = 1;
    cfg_log2len = 4'd3;
    tick();
    chk("post rst status", status, 3'd1);
    chk("post rst cur", cur_log2len, 4'd3);
    apply(0, 1);
    chk("post rst status2", status, 3'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
